// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Function : Packet-level round-robin arbiter sharing one FIFO write port
//            among NREQ valid/ready beat streams, honouring wfull.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NREQ    = 4,
    parameter int DSIZE   = 8,
    parameter int MAXBEAT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DSIZE-1:0]  req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic                   winc,
    output logic [DSIZE-1:0]       wdata,
    input  logic                   wfull,
    output logic [2:0]             gnt_id,
    output logic                   busy,
    output logic                   err_overlen
);

    localparam logic [7:0] c_MAXM1   = 8'(MAXBEAT - 1);
    localparam logic [3:0] c_NREQ    = 4'(NREQ);
    localparam logic [2:0] c_LAST_ID = 3'(NREQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            r_state;
    logic [2:0]        r_ptr;
    logic [2:0]        r_gnt;
    logic [7:0]        r_beat_cnt;

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [2:0]        w_off;
    logic [3:0]        w_sum;
    logic [2:0]        w_sel;
    logic              w_gvalid;
    logic              w_glast;
    logic [DSIZE-1:0]  w_gdata;
    logic [2:0]        w_gnt_nxt;
    logic              w_busy;
    logic              w_xfer;
    logic              w_at_max;

    // Rotate the valid vector so bit 0 is the pointer; lowest set bit wins.
    always_comb begin
        w_dbl = {req_valid, req_valid};
        w_rot = NREQ'(w_dbl >> r_ptr);
        w_off = '0;
        for (int o = NREQ - 1; o >= 0; o--) begin
            if (w_rot[o]) begin
                w_off = 3'(o);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        w_sel = (w_sum >= c_NREQ) ? 3'(w_sum - c_NREQ) : w_sum[2:0];
    end

    always_comb begin
        w_gvalid  = 1'b0;
        w_glast   = 1'b0;
        w_gdata   = '0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_gnt == 3'(k)) begin
                w_gvalid     = req_valid[k];
                w_glast      = req_last[k];
                w_gdata      = req_data[k*DSIZE +: DSIZE];
                req_ready[k] = w_busy & ~wfull;
            end
        end
    end

    assign w_busy      = (r_state == ST_GRANT);
    assign w_xfer      = w_busy & w_gvalid & ~wfull;
    assign w_at_max    = (r_beat_cnt == c_MAXM1);
    assign w_gnt_nxt   = (r_gnt == c_LAST_ID) ? 3'd0 : r_gnt + 3'd1;

    assign winc        = w_xfer;
    assign wdata       = w_gdata;
    assign gnt_id      = r_gnt;
    assign busy        = w_busy;
    assign err_overlen = w_xfer & ~w_glast & w_at_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        r_gnt      <= w_sel;
                        r_beat_cnt <= '0;
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        // A full-length packet without last is cut here;
                        // its remaining beats re-arbitrate as a new packet.
                        if (w_glast || w_at_max) begin
                            r_ptr   <= w_gnt_nxt;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
